// File: rtl/serdesphy_rx_word_aligner.sv
// serdesphy_rx_word_aligner: slides over the deserialised bit stream to find
// the sync word, verifies and locks word alignment, then emits data words.
// Optional macro SERDESPHY_RX_ALIGN_POLARITY_EN: also lock onto an
// inverted-polarity stream and correct it on the fly.
module serdesphy_rx_word_aligner #(
    parameter int                WORD_W       = 16,
    parameter logic [WORD_W-1:0] SYNC_PATTERN = WORD_W'(16'hA5A5),
    parameter int                LOCK_CNT     = 4,
    parameter int                SYNC_PERIOD  = 8,
    parameter int                UNLOCK_CNT   = 3
) (
    input  logic              clk_240m_rx,
    input  logic              rst_n_240m_rx,
    input  logic              enable,
    input  logic              align_rst,
    input  logic              serial_data,
    input  logic              serial_valid,
    input  logic              serial_error,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              aligned,
    output logic [7:0]        slip_count,
    output logic              lock_lost,
    output logic              rx_inverted
);

    localparam int FW = $clog2(WORD_W + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int SW = $clog2(SYNC_PERIOD + 1);
    localparam int XW = $clog2(UNLOCK_CNT + 1);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_VERIFY = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic [1:0]        state;
    logic [WORD_W-1:0] sr;
    logic [FW-1:0]     fill_cnt;
    logic [FW-1:0]     bit_cnt;
    logic [MW-1:0]     match_cnt;
    logic [SW-1:0]     since_cnt;
    logic [XW-1:0]     miss_cnt;

    logic              bit_acc;
    logic              bit_in;
    logic [WORD_W-1:0] sr_shift;
    logic [FW-1:0]     fill_inc;
    logic              fill_done;
    logic              boundary;
    logic              is_sync;
    logic              is_inv;
    logic              match_last;
    logic              since_last;
    logic              miss_last;

    // Per-bit helpers: post-shift window, boundary and counter terminal flags
    always_comb begin
        bit_acc    = serial_valid & ~serial_error;
        bit_in     = serial_data ^ rx_inverted;
        sr_shift   = {sr[WORD_W-2:0], bit_in};
        fill_done  = (fill_cnt >= FW'(WORD_W - 1));
        fill_inc   = (fill_cnt == FW'(WORD_W)) ? fill_cnt : fill_cnt + 1'b1;
        boundary   = (bit_cnt == FW'(WORD_W - 1));
        is_sync    = (sr_shift == SYNC_PATTERN);
        is_inv     = (sr_shift == ~SYNC_PATTERN);
        match_last = (match_cnt == MW'(LOCK_CNT - 1));
        since_last = (since_cnt == SW'(SYNC_PERIOD - 1));
        miss_last  = (miss_cnt == XW'(UNLOCK_CNT - 1));
    end

    // Alignment FSM, counters and registered outputs
    always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
        if (!rst_n_240m_rx) begin
            state       <= S_SEARCH;
            sr          <= '0;
            fill_cnt    <= '0;
            bit_cnt     <= '0;
            match_cnt   <= '0;
            since_cnt   <= '0;
            miss_cnt    <= '0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            aligned     <= 1'b0;
            slip_count  <= '0;
            lock_lost   <= 1'b0;
            rx_inverted <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (align_rst || !enable) begin
                state     <= S_SEARCH;
                fill_cnt  <= '0;
                bit_cnt   <= '0;
                match_cnt <= '0;
                since_cnt <= '0;
                miss_cnt  <= '0;
                aligned   <= 1'b0;
                if (align_rst) begin
                    slip_count  <= '0;
                    lock_lost   <= 1'b0;
                    rx_inverted <= 1'b0;
                end
            end else if (bit_acc) begin
                sr <= sr_shift;
                unique case (state)
                    S_SEARCH: begin
                        fill_cnt <= fill_inc;
                        if (fill_done && is_sync) begin
                            bit_cnt   <= '0;
                            match_cnt <= MW'(1);
                            since_cnt <= '0;
                            miss_cnt  <= '0;
                            if (LOCK_CNT == 1) begin
                                state   <= S_LOCKED;
                                aligned <= 1'b1;
                            end else begin
                                state <= S_VERIFY;
                            end
                        end
`ifdef SERDESPHY_RX_ALIGN_POLARITY_EN
                        else if (fill_done && is_inv) begin
                            // Flip the window now so VERIFY sees the true word
                            rx_inverted <= 1'b1;
                            sr          <= ~sr_shift;
                            bit_cnt     <= '0;
                            match_cnt   <= MW'(1);
                            since_cnt   <= '0;
                            miss_cnt    <= '0;
                            if (LOCK_CNT == 1) begin
                                state   <= S_LOCKED;
                                aligned <= 1'b1;
                            end else begin
                                state <= S_VERIFY;
                            end
                        end
`endif
                    end
                    S_VERIFY: begin
                        if (boundary) begin
                            bit_cnt <= '0;
                            if (is_sync) begin
                                if (match_last) begin
                                    state     <= S_LOCKED;
                                    aligned   <= 1'b1;
                                    since_cnt <= '0;
                                    miss_cnt  <= '0;
                                end else begin
                                    match_cnt <= match_cnt + 1'b1;
                                end
                            end else begin
                                // Fill stays full so sliding resumes at once
                                state     <= S_SEARCH;
                                match_cnt <= '0;
                                if (slip_count != 8'hFF) begin
                                    slip_count <= slip_count + 8'd1;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_LOCKED: begin
                        if (boundary) begin
                            bit_cnt <= '0;
                            if (is_sync) begin
                                since_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                word_out   <= sr_shift;
                                word_valid <= 1'b1;
                                if (since_last) begin
                                    since_cnt <= '0;
                                    if (miss_last) begin
                                        state     <= S_SEARCH;
                                        aligned   <= 1'b0;
                                        lock_lost <= 1'b1;
                                        fill_cnt  <= '0;
                                        match_cnt <= '0;
                                        miss_cnt  <= '0;
                                    end else begin
                                        miss_cnt <= miss_cnt + 1'b1;
                                    end
                                end else begin
                                    since_cnt <= since_cnt + 1'b1;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_SEARCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serdesphy_rx_word_aligner.sv
// tb_serdesphy_rx_word_aligner: directed sequence with random filler,
// checked every cycle against a bit-history reference model.
module tb_serdesphy_rx_word_aligner;

    localparam int          W     = 16;
    localparam logic [15:0] SYNC  = 16'hA5A5;
    localparam int          LOCKN = 4;
    localparam int          PER   = 8;
    localparam int          UNL   = 3;

    logic        clk_240m_rx;
    logic        rst_n_240m_rx;
    logic        enable;
    logic        align_rst;
    logic        serial_data;
    logic        serial_valid;
    logic        serial_error;
    logic [15:0] word_out;
    logic        word_valid;
    logic        aligned;
    logic [7:0]  slip_count;
    logic        lock_lost;
    logic        rx_inverted;

    serdesphy_rx_word_aligner #(
        .WORD_W      (W),
        .SYNC_PATTERN(SYNC),
        .LOCK_CNT    (LOCKN),
        .SYNC_PERIOD (PER),
        .UNLOCK_CNT  (UNL)
    ) dut (
        .clk_240m_rx  (clk_240m_rx),
        .rst_n_240m_rx(rst_n_240m_rx),
        .enable       (enable),
        .align_rst    (align_rst),
        .serial_data  (serial_data),
        .serial_valid (serial_valid),
        .serial_error (serial_error),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .aligned      (aligned),
        .slip_count   (slip_count),
        .lock_lost    (lock_lost),
        .rx_inverted  (rx_inverted)
    );

    initial clk_240m_rx = 1'b0;
    always #5 clk_240m_rx = ~clk_240m_rx;

    int n_cmp = 0;
    int n_bad = 0;
    int n_strobe = 0;
    logic [15:0] last_word = '0;

    // reference model: mode 0 hunting, 1 confirming, 2 locked
    int          m_mode = 0;
    bit          m_hist[$];
    int          m_nacc = 0;
    int          m_anchor = 0;
    int          m_syncs = 0;
    int          m_data = 0;
    int          m_miss = 0;
    logic [15:0] e_word = '0;
    bit          e_wv = 0;
    bit          e_al = 0;
    bit          e_lost = 0;
    bit          e_inv = 0;
    int          e_slip = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_window();
        logic [15:0] w = '0;
        foreach (m_hist[i]) w = {w[14:0], m_hist[i]};
        return w;
    endfunction

    task automatic m_lock();
        m_mode = 2;
        e_al   = 1;
        m_data = 0;
        m_miss = 0;
    endtask

    task automatic model_step(input bit d, input bit v, input bit er,
                              input bit en, input bit ar);
        logic [15:0] w;
        e_wv = 0;
        if (ar || !en) begin
            m_mode = 0;
            m_hist.delete();
            e_al = 0;
            if (ar) begin
                e_slip = 0;
                e_lost = 0;
                e_inv  = 0;
            end
        end else if (v && !er) begin
            m_hist.push_back(d ^ e_inv);
            if (m_hist.size() > W) void'(m_hist.pop_front());
            m_nacc++;
            w = m_window();
            if (m_mode == 0) begin
                if (m_hist.size() == W) begin
                    if (w == SYNC) begin
                        m_anchor = m_nacc;
                        m_syncs  = 1;
                        if (LOCKN == 1) m_lock(); else m_mode = 1;
                    end
`ifdef SERDESPHY_RX_ALIGN_POLARITY_EN
                    else if (w == ~SYNC) begin
                        e_inv = 1;
                        foreach (m_hist[i]) m_hist[i] = ~m_hist[i];
                        m_anchor = m_nacc;
                        m_syncs  = 1;
                        if (LOCKN == 1) m_lock(); else m_mode = 1;
                    end
`endif
                end
            end else if ((m_nacc - m_anchor) % W == 0) begin
                if (m_mode == 1) begin
                    if (w == SYNC) begin
                        m_syncs++;
                        if (m_syncs == LOCKN) m_lock();
                    end else begin
                        m_mode = 0;
                        if (e_slip < 255) e_slip++;
                    end
                end else if (w == SYNC) begin
                    m_data = 0;
                    m_miss = 0;
                end else begin
                    e_word = w;
                    e_wv   = 1;
                    m_data++;
                    if (m_data == PER) begin
                        m_data = 0;
                        m_miss++;
                        if (m_miss == UNL) begin
                            m_mode = 0;
                            e_al   = 0;
                            e_lost = 1;
                            m_miss = 0;
                            m_hist.delete();
                        end
                    end
                end
            end
        end
    endtask

    // called at a negedge; returns at the next negedge
    task automatic cycle(input logic d, input logic v, input logic er,
                         input logic en, input logic ar);
        serial_data  = d;
        serial_valid = v;
        serial_error = er;
        enable       = en;
        align_rst    = ar;
        @(posedge clk_240m_rx);
        #1;
        model_step(d, v, er, en, ar);
        chk("word_valid", 32'(word_valid), 32'(e_wv));
        chk("aligned", 32'(aligned), 32'(e_al));
        chk("slip_count", 32'(slip_count), 32'(e_slip));
        chk("lock_lost", 32'(lock_lost), 32'(e_lost));
        chk("rx_inverted", 32'(rx_inverted), 32'(e_inv));
        if (e_wv) chk("word_out", 32'(word_out), 32'(e_word));
        if (word_valid) begin
            n_strobe++;
            last_word = word_out;
        end
        @(negedge clk_240m_rx);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) cycle(w[i], 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] d = 16'($urandom);
        if (d == SYNC || d == ~SYNC) d = d ^ 16'h0001;
        return d;
    endfunction

    initial begin
        logic [4:0]  junk;
        logic [15:0] pat;

        // reset with random inputs
        rst_n_240m_rx = 1'b0;
        enable = 1'b0; align_rst = 1'b0;
        serial_data = 1'b0; serial_valid = 1'b0; serial_error = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_240m_rx);
            serial_data  = 1'($urandom);
            serial_valid = 1'($urandom);
            serial_error = 1'($urandom);
            enable       = 1'($urandom);
            align_rst    = 1'($urandom);
            @(posedge clk_240m_rx);
            #1;
            chk("rst_word_out", 32'(word_out), 32'd0);
            chk("rst_word_valid", 32'(word_valid), 32'd0);
            chk("rst_aligned", 32'(aligned), 32'd0);
            chk("rst_slip", 32'(slip_count), 32'd0);
            chk("rst_lock_lost", 32'(lock_lost), 32'd0);
            chk("rst_rx_inv", 32'(rx_inverted), 32'd0);
        end
        @(negedge clk_240m_rx);
        rst_n_240m_rx = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 5 junk bits, 4 syncs: lock on the 69th accepted bit
        junk = 5'($urandom);
        if (junk[3:0] == 4'b0101) junk[0] = 1'b0;
        for (int i = 4; i >= 0; i--) cycle(junk[i], 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) send_word(SYNC);
        pat = SYNC;
        for (int i = 15; i >= 1; i--) cycle(pat[i], 1'b1, 1'b0, 1'b1, 1'b0);
        chk("no_lock_bit68", 32'(aligned), 32'd0);
        chk("no_strobe_search", 32'(n_strobe), 32'd0);
        cycle(pat[0], 1'b1, 1'b0, 1'b1, 1'b0);
        chk("lock_bit69", 32'(aligned), 32'd1);
        n_strobe = 0;
        send_word(16'h1234);
        chk("first_strobes", 32'(n_strobe), 32'd1);
        chk("first_word", 32'(last_word), 32'h1234);
        chk("first_slip", 32'(slip_count), 32'd0);

        // disable, then a failed verify
        cycle(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("disable_aligned", 32'(aligned), 32'd0);
        send_word(SYNC);
        send_word(SYNC);
        send_word(16'h0000);
        chk("slip_one", 32'(slip_count), 32'd1);
        chk("slip_aligned", 32'(aligned), 32'd0);
        for (int k = 0; k < 4; k++) send_word(SYNC);
        chk("relock", 32'(aligned), 32'd1);

        // 24 data words without sync drop lock
        n_strobe = 0;
        for (int k = 0; k < 24; k++) begin
            send_word(rand_data());
            if (k == 22) chk("held_word23", 32'(aligned), 32'd1);
        end
        chk("timeout_strobes", 32'(n_strobe), 32'd24);
        chk("timeout_aligned", 32'(aligned), 32'd0);
        chk("timeout_lost", 32'(lock_lost), 32'd1);

        // sync every 7 words keeps lock
        for (int k = 0; k < 4; k++) send_word(SYNC);
        n_strobe = 0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 7; k++) send_word(rand_data());
            send_word(SYNC);
        end
        chk("period7_aligned", 32'(aligned), 32'd1);
        chk("period7_strobes", 32'(n_strobe), 32'd35);
        chk("lost_sticky", 32'(lock_lost), 32'd1);

        // gap and errored bit inside a word
        n_strobe = 0;
        pat = 16'h1234;
        for (int i = 15; i >= 0; i--) begin
            cycle(pat[i], 1'b1, 1'b0, 1'b1, 1'b0);
            if (i == 10) cycle(1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 6) cycle(1'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
        end
        chk("gap_strobes", 32'(n_strobe), 32'd1);
        chk("gap_word", 32'(last_word), 32'h1234);

        // align_rst wins over a valid bit
        cycle(1'($urandom), 1'b1, 1'b0, 1'b1, 1'b1);
        chk("arst_aligned", 32'(aligned), 32'd0);
        chk("arst_slip", 32'(slip_count), 32'd0);
        chk("arst_lost", 32'(lock_lost), 32'd0);

        // inverted-polarity stream
        n_strobe = 0;
        for (int k = 0; k < 4; k++) send_word(~SYNC);
        send_word(~16'h1234);
`ifdef SERDESPHY_RX_ALIGN_POLARITY_EN
        chk("inv_aligned", 32'(aligned), 32'd1);
        chk("inv_flag", 32'(rx_inverted), 32'd1);
        chk("inv_strobes", 32'(n_strobe), 32'd1);
        chk("inv_word", 32'(last_word), 32'h1234);
`else
        chk("inv_aligned", 32'(aligned), 32'd0);
        chk("inv_flag", 32'(rx_inverted), 32'd0);
        chk("inv_strobes", 32'(n_strobe), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
